pipeline_hazard_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 5-stage RISC-V pipeline.

---
 rtl/riscv_pipe_pkg.sv | 16 +
 rtl/pipeline_hazard_ctrl_mc_busy_fsm.sv | 69 ++++++
 rtl/pipeline_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and
// the multi-cycle EX sequencer state.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_mc_busy_fsm.sv
// Multi-cycle EX sequencer: holds the front of the pipe while a MUL/DIV occupies
// EX for exactly MUL_LAT cycles and pulses MulDoneE in the last one.
//
//  state | meaning
//  IDLE  | no multi-cycle op in EX; a MulStartE stalls this cycle and loads cnt
//  BUSY  | op in flight; stall while cnt!=0, done pulse when cnt==0
module mc_busy_fsm
    import riscv_pipe_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic MulStartE,
    output logic mc_stall,
    output logic MulDoneE
);

    localparam int CNT_W = $clog2(MUL_LAT);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 2);

    mc_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (MulStartE) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mc_stall = 1'b0;
        MulDoneE = 1'b0;
        case (state)
            IDLE:    mc_stall = MulStartE;
            BUSY: begin
                mc_stall = (cnt != '0);
                MulDoneE = (cnt == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipe: stall/flush priority and EX forwarding.
// Define HAZ_FORWARDING_EN for forwarding + load-use; otherwise every RAW stalls.
module pipeline_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              RegWriteE,
    input  logic              LoadE,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              MulStartE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MulDoneE
);

    logic     mc_stall;
    logic     mc_done;
    logic     raw_stall;
    fwd_sel_t fwd_a;
    fwd_sel_t fwd_b;

    mc_busy_fsm #(.MUL_LAT(MUL_LAT)) u_mc_busy_fsm (
        .clk       (clk),
        .reset     (reset),
        .MulStartE (MulStartE),
        .mc_stall  (mc_stall),
        .MulDoneE  (mc_done)
    );

`ifdef HAZ_FORWARDING_EN
    function automatic fwd_sel_t pick_fwd(
        input logic [REG_AW-1:0] rs,
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] rd_w
    );
        if (wr_m && rd_m != '0 && rd_m == rs)      return FWD_MEM;
        else if (wr_w && rd_w != '0 && rd_w == rs) return FWD_WB;
        else                                       return FWD_RF;
    endfunction

    assign fwd_a = pick_fwd(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    assign fwd_b = pick_fwd(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    assign raw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    logic unused_cfg;
    assign unused_cfg = RegWriteE;
`else
    // Without bypass paths, any producer still in EX or MEM must drain first;
    // WB is covered by the write-first register file.
    logic raw_e, raw_m;
    assign raw_e = RegWriteE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign raw_m = RegWriteM && (RdM != '0) && ((RdM == Rs1D) || (RdM == Rs2D));
    assign raw_stall = raw_e || raw_m;
    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;

    logic unused_cfg;
    assign unused_cfg = ^{Rs1E, Rs2E, RdW, RegWriteW, LoadE};
`endif

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        MulDoneE  = 1'b0;
        if (reset) begin
            if (mc_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (PCSrcE) begin
                // ID holds a wrong-path instruction, so its hazards are moot.
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (raw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            MulDoneE  = mc_done;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a MUL_LAT=4 and a MUL_LAT=2 instance share stimulus.
module tb_pipeline_hazard_ctrl;

`ifdef HAZ_FORWARDING_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    // {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDoneE}
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] MC   = 7'b1110010;
    localparam logic [6:0] DONE = 7'b0000001;
    localparam logic [6:0] BR   = 7'b0001100;
    localparam logic [6:0] LU   = 7'b1100100;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, LoadE, RegWriteM, RegWriteW, PCSrcE, MulStartE;

    logic       StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, MulDoneE1;
    logic [1:0] ForwardAE1, ForwardBE1;
    logic       StallF2, StallD2, StallE2, FlushD2, FlushE2, FlushM2, MulDoneE2;
    logic [1:0] ForwardAE2, ForwardBE2;

    logic [6:0] ctl1, ctl2;
    logic [3:0] fwd1;
    assign ctl1 = {StallF1, StallD1, StallE1, FlushD1, FlushE1, FlushM1, MulDoneE1};
    assign ctl2 = {StallF2, StallD2, StallE2, FlushD2, FlushE2, FlushM2, MulDoneE2};
    assign fwd1 = {ForwardAE1, ForwardBE1};

    int n_chk  = 0;
    int n_pass = 0;

    pipeline_hazard_ctrl #(.MUL_LAT(4), .REG_AW(5)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RegWriteE(RegWriteE), .LoadE(LoadE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MulStartE(MulStartE),
        .StallF(StallF1), .StallD(StallD1), .StallE(StallE1),
        .FlushD(FlushD1), .FlushE(FlushE1), .FlushM(FlushM1),
        .ForwardAE(ForwardAE1), .ForwardBE(ForwardBE1), .MulDoneE(MulDoneE1)
    );

    pipeline_hazard_ctrl #(.MUL_LAT(2), .REG_AW(5)) dut2 (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RegWriteE(RegWriteE), .LoadE(LoadE),
        .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MulStartE(MulStartE),
        .StallF(StallF2), .StallD(StallD2), .StallE(StallE2),
        .FlushD(FlushD2), .FlushE(FlushE2), .FlushM(FlushM2),
        .ForwardAE(ForwardAE2), .ForwardBE(ForwardBE2), .MulDoneE(MulDoneE2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Inputs are applied just after posedge; outputs are checked on the negedge.
    task automatic cyc(input string tag, input logic [6:0] e1, input logic [3:0] ef,
                       input logic [6:0] e2);
        @(negedge clk);
        chk({tag, "/ctl4"}, {1'b0, ctl1}, {1'b0, e1});
        chk({tag, "/fwd"},  {4'b0, fwd1}, {4'b0, ef});
        chk({tag, "/ctl2"}, {1'b0, ctl2}, {1'b0, e2});
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteE = 1'b0; LoadE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        PCSrcE = 1'b0; MulStartE = 1'b0;
    endtask

    initial begin
        clr();
        reset = 1'b0;
        @(posedge clk);
        #1;
        PCSrcE = 1'b1; MulStartE = 1'b1; RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
        cyc("rst_low", NONE, 4'b0000, NONE);
        clr(); reset = 1'b1;
        cyc("idle", NONE, 4'b0000, NONE);

        // forwarding
        RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5;
        cyc("fwd_mem", NONE, FWD_ON ? 4'b1000 : 4'b0000, NONE);
        RdM = 5'd0;
        cyc("fwd_wb", NONE, FWD_ON ? 4'b0100 : 4'b0000, NONE);
        RdM = 5'd5; Rs2E = 5'd5;
        cyc("fwd_both", NONE, FWD_ON ? 4'b1010 : 4'b0000, NONE);
        RegWriteM = 1'b0;
        cyc("fwd_nowrm", NONE, FWD_ON ? 4'b0101 : 4'b0000, NONE);
        RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        cyc("fwd_x0", NONE, 4'b0000, NONE);

        // load-use, then the load drains through MEM and WB
        clr(); LoadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs1D = 5'd1; Rs2D = 5'd7;
        cyc("lu_e", LU, 4'b0000, LU);
        LoadE = 1'b0; RegWriteE = 1'b0; RdE = 5'd0; RegWriteM = 1'b1; RdM = 5'd7;
        cyc("lu_m", FWD_ON ? NONE : LU, 4'b0000, FWD_ON ? NONE : LU);
        RegWriteM = 1'b0; RdM = 5'd0; RegWriteW = 1'b1; RdW = 5'd7;
        cyc("lu_w", NONE, 4'b0000, NONE);
        clr(); LoadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd0;
        cyc("lu_x0", NONE, 4'b0000, NONE);
        RdE = 5'd9; Rs1D = 5'd9;
        cyc("lu_rs1", LU, 4'b0000, LU);
        Rs1D = 5'd8; Rs2D = 5'd10;
        cyc("lu_nomatch", NONE, 4'b0000, NONE);

        // RAW without load: only stalls when bypassing is absent
        clr(); RegWriteE = 1'b1; RdE = 5'd3; Rs1D = 5'd3;
        cyc("raw_e", FWD_ON ? NONE : LU, 4'b0000, FWD_ON ? NONE : LU);
        RegWriteE = 1'b0; RdE = 5'd0; RegWriteM = 1'b1; RdM = 5'd3;
        cyc("raw_m", FWD_ON ? NONE : LU, 4'b0000, FWD_ON ? NONE : LU);
        RegWriteM = 1'b0; RdM = 5'd0; RegWriteW = 1'b1; RdW = 5'd3;
        cyc("raw_w", NONE, 4'b0000, NONE);

        // branch alone and against a load-use hazard
        clr(); PCSrcE = 1'b1;
        cyc("br", BR, 4'b0000, BR);
        LoadE = 1'b1; RegWriteE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        cyc("br_lu", BR, 4'b0000, BR);

        // multi-cycle op: masks branch/load-use, held start restarts only from IDLE
        MulStartE = 1'b1;
        cyc("mul_c1", MC, 4'b0000, MC);
        clr(); MulStartE = 1'b1;
        cyc("mul_c2", MC, 4'b0000, DONE);
        cyc("mul_c3", MC, 4'b0000, MC);
        cyc("mul_c4", DONE, 4'b0000, DONE);
        cyc("mul_c5", MC, 4'b0000, MC);
        MulStartE = 1'b0;
        cyc("mul_c6", MC, 4'b0000, DONE);
        cyc("mul_c7", MC, 4'b0000, NONE);
        PCSrcE = 1'b1;
        cyc("mul_c8", DONE | BR, 4'b0000, BR);
        PCSrcE = 1'b0;
        cyc("mul_c9", NONE, 4'b0000, NONE);

        // reset mid-op (cnt==1 in the LAT=4 instance) abandons the op
        MulStartE = 1'b1;
        cyc("rmo_1", MC, 4'b0000, MC);
        cyc("rmo_2", MC, 4'b0000, DONE);
        MulStartE = 1'b0; reset = 1'b0; PCSrcE = 1'b1;
        cyc("rmo_rst", NONE, 4'b0000, NONE);
        reset = 1'b1; PCSrcE = 1'b0;
        cyc("rmo_after1", NONE, 4'b0000, NONE);
        cyc("rmo_after2", NONE, 4'b0000, NONE);
        MulStartE = 1'b1;
        cyc("rmo_r1", MC, 4'b0000, MC);
        MulStartE = 1'b0;
        cyc("rmo_r2", MC, 4'b0000, DONE);
        cyc("rmo_r3", MC, 4'b0000, NONE);
        cyc("rmo_r4", DONE, 4'b0000, NONE);
        cyc("rmo_r5", NONE, 4'b0000, NONE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
